regfile_write_arbiter: RTL and testbench

Shares the single write port of the 64×32 register file between two writeback requesters (A: ALU writeback, B: load/memory writeback). Each requester has a small FIFO, and a round-robin arbiter drains the FIFOs at one write per cycle into registered `write_reg`/`write_data`/`reg_write` outputs, which connect directly to the register file. The block also reports read-after-write hazards for the register file's two read addresses so that issue logic can stall.

---
 rtl/regfile_write_arbiter.sv | 158 +++++++++++++++
 tb/tb_regfile_write_arbiter.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// Two-requester writeback arbiter for the register file write port, with per-requester FIFOs,
// round-robin draining and read-after-write hazard reporting for two read addresses.
module regfile_write_arbiter #(
    parameter int unsigned AW    = 6,
    parameter int unsigned DW    = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          a_valid,
    output logic          a_ready,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_data,
    input  logic          b_valid,
    output logic          b_ready,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_data,
    output logic [AW-1:0] write_reg,
    output logic [DW-1:0] write_data,
    output logic          reg_write,
    input  logic [AW-1:0] read1,
    input  logic [AW-1:0] read2,
    output logic          busy1,
    output logic          busy2,
    output logic          idle
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [AW-1:0] a_addr_q [DEPTH];
    logic [DW-1:0] a_data_q [DEPTH];
    logic [AW-1:0] b_addr_q [DEPTH];
    logic [DW-1:0] b_data_q [DEPTH];

    logic [PW-1:0] a_rd_q, a_rd_d, a_wr_q, a_wr_d;
    logic [PW-1:0] b_rd_q, b_rd_d, b_wr_q, b_wr_d;
    logic [CW-1:0] a_cnt_q, a_cnt_d, b_cnt_q, b_cnt_d;
    logic          last_q, last_d;  // 0: A granted most recently, 1: B

    logic [AW-1:0] write_reg_q, write_reg_d;
    logic [DW-1:0] write_data_q, write_data_d;
    logic          reg_write_q, reg_write_d;

    logic a_push, b_push, a_empty, b_empty, grant_a, grant_b;
    logic [AW-1:0] head_addr;
    logic [DW-1:0] head_data;
    logic [DEPTH-1:0] a_vld, b_vld;

    assign a_ready = (a_cnt_q != CW'(DEPTH));
    assign b_ready = (b_cnt_q != CW'(DEPTH));
    assign a_push  = a_valid && a_ready;
    assign b_push  = b_valid && b_ready;
    assign a_empty = (a_cnt_q == '0);
    assign b_empty = (b_cnt_q == '0);

    assign grant_a = !a_empty && (b_empty || last_q);
    assign grant_b = !b_empty && (a_empty || !last_q);

    always_comb begin
        head_addr = b_addr_q[b_rd_q];
        head_data = b_data_q[b_rd_q];
        if (grant_a) begin
            head_addr = a_addr_q[a_rd_q];
            head_data = a_data_q[a_rd_q];
        end
    end

    always_comb begin
        a_wr_d  = a_push  ? a_wr_q + PW'(1) : a_wr_q;
        b_wr_d  = b_push  ? b_wr_q + PW'(1) : b_wr_q;
        a_rd_d  = grant_a ? a_rd_q + PW'(1) : a_rd_q;
        b_rd_d  = grant_b ? b_rd_q + PW'(1) : b_rd_q;
        a_cnt_d = a_cnt_q;
        b_cnt_d = b_cnt_q;
        if (a_push && !grant_a) a_cnt_d = a_cnt_q + CW'(1);
        else if (!a_push && grant_a) a_cnt_d = a_cnt_q - CW'(1);
        if (b_push && !grant_b) b_cnt_d = b_cnt_q + CW'(1);
        else if (!b_push && grant_b) b_cnt_d = b_cnt_q - CW'(1);
        last_d       = last_q;
        write_reg_d  = write_reg_q;
        write_data_d = write_data_q;
        reg_write_d  = 1'b0;
        if (grant_a || grant_b) begin
            last_d       = grant_b;
            write_reg_d  = head_addr;
            write_data_d = head_data;
            // Writes to register 0 are drained but never reach the register file.
            reg_write_d  = (head_addr != '0);
        end
    end

    always_ff @(posedge clock) begin
        if (a_push) begin
            a_addr_q[a_wr_q] <= a_addr;
            a_data_q[a_wr_q] <= a_data;
        end
        if (b_push) begin
            b_addr_q[b_wr_q] <= b_addr;
            b_data_q[b_wr_q] <= b_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            a_rd_q       <= '0;
            a_wr_q       <= '0;
            a_cnt_q      <= '0;
            b_rd_q       <= '0;
            b_wr_q       <= '0;
            b_cnt_q      <= '0;
            last_q       <= 1'b1;
            write_reg_q  <= '0;
            write_data_q <= '0;
            reg_write_q  <= 1'b0;
        end else begin
            a_rd_q       <= a_rd_d;
            a_wr_q       <= a_wr_d;
            a_cnt_q      <= a_cnt_d;
            b_rd_q       <= b_rd_d;
            b_wr_q       <= b_wr_d;
            b_cnt_q      <= b_cnt_d;
            last_q       <= last_d;
            write_reg_q  <= write_reg_d;
            write_data_q <= write_data_d;
            reg_write_q  <= reg_write_d;
        end
    end

    // Slot i holds a live entry when its distance from the read pointer is below the count.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            a_vld[i] = ({1'b0, PW'(PW'(i) - a_rd_q)} < a_cnt_q);
            b_vld[i] = ({1'b0, PW'(PW'(i) - b_rd_q)} < b_cnt_q);
        end
    end

    always_comb begin
        busy1 = reg_write_q && (write_reg_q == read1);
        busy2 = reg_write_q && (write_reg_q == read2);
        for (int i = 0; i < DEPTH; i++) begin
            if ((a_vld[i] && a_addr_q[i] == read1) || (b_vld[i] && b_addr_q[i] == read1)) begin
                busy1 = 1'b1;
            end
            if ((a_vld[i] && a_addr_q[i] == read2) || (b_vld[i] && b_addr_q[i] == read2)) begin
                busy2 = 1'b1;
            end
        end
        if (read1 == '0) busy1 = 1'b0;
        if (read2 == '0) busy2 = 1'b0;
    end

    assign write_reg  = write_reg_q;
    assign write_data = write_data_q;
    assign reg_write  = reg_write_q;
    assign idle       = a_empty && b_empty && !reg_write_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: a behavioural queue model predicts ready, hazard,
// idle and the registered write port; expected write-port values are queued per edge.
module tb_regfile_write_arbiter;

    localparam int DEPTH = 2;

    typedef struct packed {
        logic [5:0]  addr;
        logic [31:0] data;
    } ent_t;

    typedef struct packed {
        logic        rw;
        logic [5:0]  wr;
        logic [31:0] wd;
    } out_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        a_valid, b_valid, a_ready, b_ready;
    logic [5:0]  a_addr, b_addr, write_reg, read1, read2;
    logic [31:0] a_data, b_data, write_data;
    logic        reg_write, busy1, busy2, idle;

    regfile_write_arbiter #(.AW(6), .DW(32), .DEPTH(DEPTH)) dut (
        .clock      (clock),
        .reset      (reset),
        .a_valid    (a_valid),
        .a_ready    (a_ready),
        .a_addr     (a_addr),
        .a_data     (a_data),
        .b_valid    (b_valid),
        .b_ready    (b_ready),
        .b_addr     (b_addr),
        .b_data     (b_data),
        .write_reg  (write_reg),
        .write_data (write_data),
        .reg_write  (reg_write),
        .read1      (read1),
        .read2      (read2),
        .busy1      (busy1),
        .busy2      (busy2),
        .idle       (idle)
    );

    always #5 clock = ~clock;

    int   n_checks = 0;
    int   n_err    = 0;
    ent_t qa[$];
    ent_t qb[$];
    out_t exp_q[$];
    out_t cur = '0;
    logic last = 1'b1;
    logic a_acc, b_acc;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic model_busy(input logic [5:0] r);
        logic hit;
        hit = cur.rw && (cur.wr == r);
        foreach (qa[i]) if (qa[i].addr == r) hit = 1'b1;
        foreach (qb[i]) if (qb[i].addr == r) hit = 1'b1;
        return hit && (r != 6'd0);
    endfunction

    // One clock cycle: drive, check combinational outputs, advance the model, check write port.
    task automatic step(input logic rst,
                        input logic av, input logic [5:0] aa, input logic [31:0] ad,
                        input logic bv, input logic [5:0] ba, input logic [31:0] bd,
                        input logic [5:0] r1, input logic [5:0] r2,
                        output logic acc_a, output logic acc_b);
        logic ra, rb, ga, gb;
        ent_t h;
        out_t e;
        reset = rst; a_valid = av; a_addr = aa; a_data = ad;
        b_valid = bv; b_addr = ba; b_data = bd; read1 = r1; read2 = r2;
        #1;
        ra = (qa.size() != DEPTH);
        rb = (qb.size() != DEPTH);
        check_eq("a_ready", a_ready, ra);
        check_eq("b_ready", b_ready, rb);
        check_eq("busy1", busy1, model_busy(r1));
        check_eq("busy2", busy2, model_busy(r2));
        check_eq("idle", idle, qa.size() == 0 && qb.size() == 0 && !cur.rw);
        acc_a = 1'b0;
        acc_b = 1'b0;
        if (rst) begin
            qa.delete();
            qb.delete();
            last = 1'b1;
            cur  = '0;
        end else begin
            ga = (qa.size() != 0) && (qb.size() == 0 || last);
            gb = (qb.size() != 0) && (qa.size() == 0 || !last);
            cur.rw = 1'b0;
            if (ga || gb) begin
                h = ga ? qa.pop_front() : qb.pop_front();
                cur.wr = h.addr;
                cur.wd = h.data;
                cur.rw = (h.addr != 6'd0);
                last   = gb;
            end
            if (av && ra) begin qa.push_back('{aa, ad}); acc_a = 1'b1; end
            if (bv && rb) begin qb.push_back('{ba, bd}); acc_b = 1'b1; end
        end
        exp_q.push_back(cur);
        @(posedge clock);
        @(negedge clock);
        e = exp_q.pop_front();
        check_eq("reg_write", reg_write, e.rw);
        check_eq("write_reg", write_reg, e.wr);
        check_eq("write_data", write_data, e.wd);
    endtask

    task automatic idle_steps(input int n, input logic [5:0] r1, input logic [5:0] r2);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 6'd0, 32'd0, 1'b0, 6'd0, 32'd0, r1, r2,
                                          a_acc, b_acc);
    endtask

    initial begin
        int bi;
        reset = 1'b1; a_valid = 1'b0; b_valid = 1'b0; a_addr = '0; b_addr = '0;
        a_data = '0; b_data = '0; read1 = '0; read2 = '0;
        @(posedge clock);
        @(negedge clock);

        // Requests held during reset must be dropped.
        step(1'b1, 1'b1, 6'd5, 32'd55, 1'b1, 6'd6, 32'd66, 6'd5, 6'd6, a_acc, b_acc);
        idle_steps(1, 6'd5, 6'd6);

        // Single write, register 1 watched on read1.
        step(1'b0, 1'b1, 6'd1, 32'd100, 1'b0, 6'd0, 32'd0, 6'd1, 6'd0, a_acc, b_acc);
        idle_steps(3, 6'd1, 6'd0);

        // Contention: both streaming.
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b1, 6'(2 * i + 1), 32'(1000 + i), 1'b1, 6'(2 * i + 2), 32'(2000 + i),
                 6'(2 * i + 1), 6'(2 * i + 2), a_acc, b_acc);
        end
        idle_steps(4, 6'd0, 6'd0);

        // Backpressure on B while A streams; B holds valid until accepted.
        bi = 0;
        for (int i = 0; i < 12 && bi < 3; i++) begin
            step(1'b0, 1'b1, 6'(20 + i), 32'(3000 + i), 1'b1, 6'(40 + bi), 32'(4000 + bi),
                 6'(40 + bi), 6'(20 + i), a_acc, b_acc);
            if (b_acc) bi++;
        end
        check_eq("b_all_accepted", 64'(bi), 64'd3);
        idle_steps(6, 6'd42, 6'd0);

        // Register 0 write is drained silently.
        step(1'b0, 1'b1, 6'd0, 32'hDEAD, 1'b0, 6'd0, 32'd0, 6'd0, 6'd0, a_acc, b_acc);
        idle_steps(3, 6'd0, 6'd0);

        // Hazard window on register 3.
        step(1'b0, 1'b1, 6'd3, 32'd300, 1'b0, 6'd0, 32'd0, 6'd3, 6'd0, a_acc, b_acc);
        idle_steps(4, 6'd3, 6'd0);

        // Fill both FIFOs, reset mid-traffic, then a tie must go to A.
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 6'(10 + i), 32'(500 + i), 1'b1, 6'(30 + i), 32'(600 + i),
                 6'(10 + i), 6'(30 + i), a_acc, b_acc);
        end
        step(1'b1, 1'b0, 6'd0, 32'd0, 1'b0, 6'd0, 32'd0, 6'd11, 6'd31, a_acc, b_acc);
        idle_steps(2, 6'd11, 6'd31);
        step(1'b0, 1'b1, 6'd7, 32'd700, 1'b1, 6'd8, 32'd800, 6'd7, 6'd8, a_acc, b_acc);
        idle_steps(4, 6'd7, 6'd8);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
